// File: rtl/mode_counter_pkg.sv
// rtl/mode_counter_pkg.sv - shared encodings and width helper for mode_counter
package mode_counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   // Bits needed to hold 0..value-1, never less than one bit
   function automatic int prescale_width(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mode_counter_if.sv
// rtl/mode_counter_if.sv - control/status bundle between a user and mode_counter
interface mode_counter_if #(
   parameter int Size = 8
);
   logic            clear;
   logic            load;
   logic [Size-1:0] data_i;
   logic            count;
   logic            up;
   logic            sat;
   logic [Size-1:0] limit_i;
   logic [Size-1:0] data_o;
   logic            tc_o;
   logic            ovf_o;

   modport master (
      output clear, load, data_i, count, up, sat, limit_i,
      input  data_o, tc_o, ovf_o
   );

   modport slave (
      input  clear, load, data_i, count, up, sat, limit_i,
      output data_o, tc_o, ovf_o
   );
endinterface

// File: rtl/mode_counter_prescale_tick.sv
// rtl/mode_counter_prescale_tick.sv - count-enable prescaler, one step per PreDiv enabled cycles
module prescale_tick
   import mode_counter_pkg::*;
#(
   parameter int PreDiv = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic count,
   input  logic clr,
   output logic step
);
   localparam int            W    = prescale_width(PreDiv);
   localparam logic [W-1:0] LAST = W'(PreDiv - 1);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] cnt;

   // Step fires on the enabled cycle that completes a group of PreDiv
   assign step = count & (cnt == LAST);

   // Enabled-cycle counter; idle cycles hold it, clr and a step return it to zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || step) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + ONE;
      end
   end
endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down modulo counter with wrap/saturate, load, clear, prescaler
module mode_counter
   import mode_counter_pkg::*;
#(
   parameter int Size   = 8,
   parameter int PreDiv = 1
) (
   input  logic         clock,
   input  logic         reset,
   mode_counter_if.slave bus
);
   localparam logic [Size-1:0] ONE = Size'(1);

   logic            step;
   logic            at_bound;
   logic [Size-1:0] step_value;
   logic [Size-1:0] load_value;
   logic [Size-1:0] data_q;
   logic            tc_q;
   logic            ovf_q;

   // Load and clear both restart the prescale group
   prescale_tick #(.PreDiv(PreDiv)) u_tick (
      .clock (clock),
      .reset (reset),
      .count (bus.count),
      .clr   (bus.clear | bus.load),
      .step  (step)
   );

   // Bound compare and next value for a step; data above limit counts as at the up bound
   always_comb begin
      at_bound   = 1'b0;
      step_value = data_q;
      load_value = (bus.data_i > bus.limit_i) ? bus.limit_i : bus.data_i;
      if (bus.up == DIR_UP) begin
         at_bound   = (data_q >= bus.limit_i);
         step_value = !at_bound ? data_q + ONE
                    : (bus.sat == MODE_SAT) ? bus.limit_i : '0;
      end else begin
         at_bound   = (data_q == '0);
         step_value = !at_bound ? data_q - ONE
                    : (bus.sat == MODE_SAT) ? '0 : bus.limit_i;
      end
   end

   // Count register with clear > load > step priority, terminal pulse and sticky overflow
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
         tc_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (bus.clear) begin
         data_q <= '0;
         tc_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (bus.load) begin
         data_q <= load_value;
         tc_q   <= 1'b0;
      end else if (step) begin
         data_q <= step_value;
         tc_q   <= at_bound;
         if (at_bound) begin
            ovf_q <= 1'b1;
         end
      end else begin
         tc_q <= 1'b0;
      end
   end

   assign bus.data_o = data_q;
   assign bus.tc_o   = tc_q;
   assign bus.ovf_o  = ovf_q;
endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed table-driven bench for mode_counter
module tb_mode_counter;

   typedef struct packed {
      logic       clear;
      logic       load;
      logic       count;
      logic       up;
      logic       sat;
      logic [3:0] data_i;
      logic [3:0] limit_i;
      logic [3:0] exp_data;
      logic       exp_tc;
      logic       exp_ovf;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   vec_t va[$];
   vec_t vb[$];

   mode_counter_if #(.Size(4)) if_a ();
   mode_counter_if #(.Size(4)) if_b ();

   mode_counter #(.Size(4), .PreDiv(1)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (if_a)
   );

   mode_counter #(.Size(4), .PreDiv(3)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (if_b)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic c, input logic l, input logic n, input logic u,
                               input logic s, input int di, input int li, input int ed,
                               input logic et, input logic eo);
      vec_t v;
      v.clear = c; v.load = l; v.count = n; v.up = u; v.sat = s;
      v.data_i = 4'(di); v.limit_i = 4'(li); v.exp_data = 4'(ed);
      v.exp_tc = et; v.exp_ovf = eo;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input int got, input int exp);
      checks = checks + 1;
      if (got != exp) begin
         failures = failures + 1;
         $display("FAIL %s[%0d] got=%0d exp=%0d", name, idx, got, exp);
      end
   endtask

   task automatic drive_a(input vec_t v);
      if_a.clear = v.clear; if_a.load = v.load; if_a.count = v.count;
      if_a.up = v.up; if_a.sat = v.sat; if_a.data_i = v.data_i; if_a.limit_i = v.limit_i;
   endtask

   task automatic drive_b(input vec_t v);
      if_b.clear = v.clear; if_b.load = v.load; if_b.count = v.count;
      if_b.up = v.up; if_b.sat = v.sat; if_b.data_i = v.data_i; if_b.limit_i = v.limit_i;
   endtask

   initial begin
      drive_a(mk(0, 0, 0, 1, 0, 0, 9, 0, 0, 0));
      drive_b(mk(0, 0, 0, 1, 0, 0, 9, 0, 0, 0));

      // Reset state while reset is held
      #12;
      check("rst_data", 0, int'(if_a.data_o), 0);
      check("rst_tc",   0, int'(if_a.tc_o),   0);
      check("rst_ovf",  0, int'(if_a.ovf_o),  0);
      check("rst_data_b", 0, int'(if_b.data_o), 0);
      reset = 1'b1;

      // Count to 5, then drop reset between edges
      if_a.count = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      check("pre_rst_data", 0, int'(if_a.data_o), 5);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst_data", 0, int'(if_a.data_o), 0);
      check("async_rst_tc",   0, int'(if_a.tc_o),   0);
      check("async_rst_ovf",  0, int'(if_a.ovf_o),  0);
      @(posedge clock);
      #1;
      check("held_rst_data", 0, int'(if_a.data_o), 0);
      if_a.count = 1'b0;
      reset = 1'b1;

      // Wrap up 1..9,0 with limit 9
      for (int i = 1; i <= 9; i++) va.push_back(mk(0, 0, 1, 1, 0, 0, 9, i, 0, 0));
      va.push_back(mk(0, 0, 1, 1, 0, 0, 9, 0, 1, 1));
      va.push_back(mk(0, 0, 0, 1, 0, 0, 9, 0, 0, 1));
      va.push_back(mk(1, 0, 0, 1, 0, 0, 9, 0, 0, 0));
      // Saturating down from 2
      va.push_back(mk(0, 1, 0, 0, 1, 2, 9, 2, 0, 0));
      va.push_back(mk(0, 0, 1, 0, 1, 0, 9, 1, 0, 0));
      va.push_back(mk(0, 0, 1, 0, 1, 0, 9, 0, 0, 0));
      va.push_back(mk(0, 0, 1, 0, 1, 0, 9, 0, 1, 1));
      va.push_back(mk(0, 0, 1, 0, 1, 0, 9, 0, 1, 1));
      va.push_back(mk(0, 0, 0, 0, 1, 0, 9, 0, 0, 1));
      va.push_back(mk(0, 0, 0, 0, 1, 0, 9, 0, 0, 1));
      va.push_back(mk(1, 0, 0, 0, 1, 0, 9, 0, 0, 0));
      // Load clamp and clear priority
      va.push_back(mk(0, 1, 0, 1, 0, 12, 9, 9, 0, 0));
      va.push_back(mk(1, 1, 1, 1, 0, 5, 9, 0, 0, 0));
      // Limit lowered below data
      va.push_back(mk(0, 1, 0, 1, 0, 7, 9, 7, 0, 0));
      va.push_back(mk(0, 0, 1, 1, 0, 0, 4, 0, 1, 1));
      va.push_back(mk(1, 0, 0, 1, 0, 0, 9, 0, 0, 0));
      va.push_back(mk(0, 1, 0, 1, 1, 7, 9, 7, 0, 0));
      va.push_back(mk(0, 0, 1, 1, 1, 0, 4, 4, 1, 1));
      va.push_back(mk(0, 1, 0, 1, 0, 3, 9, 3, 0, 1));
      va.push_back(mk(0, 1, 0, 1, 0, 9, 9, 9, 0, 1));
      va.push_back(mk(0, 0, 1, 0, 0, 0, 4, 8, 0, 1));
      va.push_back(mk(0, 0, 1, 1, 1, 0, 4, 4, 1, 1));
      // Limit zero
      va.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      va.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
      va.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 1));
      va.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      // Wrap down from 0
      va.push_back(mk(0, 1, 0, 0, 0, 0, 9, 0, 0, 1));
      va.push_back(mk(0, 0, 1, 0, 0, 0, 9, 9, 1, 1));

      // PreDiv=3 with a gap, then clear and load restarting the group
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 0, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 0, 0, 0));
      vb.push_back(mk(0, 0, 0, 1, 0, 0, 9, 0, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 2, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 2, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 2, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 3, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 3, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 3, 0, 0));
      vb.push_back(mk(1, 0, 0, 1, 0, 0, 9, 0, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 0, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 0, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(0, 1, 0, 1, 0, 5, 9, 5, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 5, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 5, 0, 0));
      vb.push_back(mk(0, 0, 1, 1, 0, 0, 9, 6, 0, 0));

      for (int i = 0; i < va.size(); i++) begin
         drive_a(va[i]);
         @(posedge clock);
         #1;
         check("a_data", i, int'(if_a.data_o), int'(va[i].exp_data));
         check("a_tc",   i, int'(if_a.tc_o),   int'(va[i].exp_tc));
         check("a_ovf",  i, int'(if_a.ovf_o),  int'(va[i].exp_ovf));
      end
      drive_a(mk(0, 0, 0, 1, 0, 0, 9, 0, 0, 0));

      for (int i = 0; i < vb.size(); i++) begin
         drive_b(vb[i]);
         @(posedge clock);
         #1;
         check("b_data", i, int'(if_b.data_o), int'(vb[i].exp_data));
         check("b_tc",   i, int'(if_b.tc_o),   int'(vb[i].exp_tc));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
